mc_ctrl_fsm_v2: RTL and testbench
=================================

// Module: mc_ctrl_fsm_v2
// PURPOSE
//  Next-generation multi-cycle control FSM for the ARM-subset core. Sequences fetch/decode/exec/mem/writeback.
//  Adds a variable-latency memory handshake, ARM condition-code gating from NZCV and an undefined-instruction/bus-timeout trap.
//  Sits between the instruction decoder (supplies cls_i) and the datapath (consumes the strobes).
// PARAMETERS
//  MEM_TIMEOUT  16       max wait cycles for mem_ready_i per request; 0 = never time out
//  COND_EN      1        1 = gate execution on instr_i[31:28]; 0 = execute every instruction unconditionally
//  TRAP_ON_NV   1        1 = cond 4'b1111 traps as undefined; 0 = treat as never-execute
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  instr_i      in   32  current IR contents (cond in [31:28], S bit in [20])
//  cls_i        in   3   decoded class: DP_WB, DP_NOWB, LDR, STR, B, BL, UND (see package)
//  nzcv_i       in   4   current flags {N,Z,C,V}
//  mem_ready_i  in   1   memory completes the current request this cycle
//  mem_req_o    out  1   memory request, held high until ready or timeout
//  mem_write_o  out  1   request is a store (valid only with mem_req_o)
//  write_ir_o   out  1   load IR from memory read data
//  write_pc_o   out  1   load PC from source pc_s_o
//  pc_s_o       out  2   PC source: 0 PC+4, 1 branch target, 2 trap vector
//  write_reg_o  out  1   register-file write enable
//  rd_s_o       out  2   write address: 0 rd field, 1 LR (r14)
//  w_rdata_s_o  out  2   write data: 0 ALU result, 1 memory data, 2 PC (link)
//  LA_o LB_o    out  1   latch operand registers A/B
//  LC_o         out  1   latch ALU result register
//  LF_o         out  1   latch flags
//  trap_o       out  1   one-cycle pulse on trap entry
//  trap_cause_o out  2   0 none, 1 undefined, 2 bus timeout; held until next trap or reset
//  state_o      out  3   current state for debug
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH; every output 0, trap_cause_o=0, timeout counter 0. Mid-operation reset aborts immediately; mem_req_o falls without a clock edge.
//  All strobes are Moore/registered-state decodes, asserted for exactly one cycle unless stated otherwise.
//  FETCH: mem_req_o=1, mem_write_o=0, held until mem_ready_i. On ready: write_ir_o=1, write_pc_o=1, pc_s_o=0, then go to DECODE.
//  DECODE: LA_o=LB_o=1. Next state:
//    cls_i==UND, or (cond==4'b1111 and TRAP_ON_NV) -> TRAP, cause 1
//    else COND_EN and condition fails -> FETCH, no further strobes
//    else -> EXEC
//  EXEC: LC_o=1. LF_o=instr_i[20] for DP classes, 0 otherwise.
//    B: write_pc_o=1, pc_s_o=1, then FETCH.
//    BL: same as B, plus write_reg_o=1, rd_s_o=1, w_rdata_s_o=2.
//    DP_*: go to WB. LDR/STR: go to MEM.
//  MEM: mem_req_o=1, mem_write_o=(cls_i==STR). On ready: STR goes to FETCH, LDR goes to WB.
//  WB: write_reg_o=1 unless DP_NOWB, rd_s_o=0, w_rdata_s_o = LDR ? 1 : 0. Then FETCH.
//  TRAP: write_pc_o=1, pc_s_o=2, trap_o=1, trap_cause_o updated. Then FETCH.
//  Timeout counter:
//    cleared on entry to FETCH/MEM; increments each cycle mem_req_o=1 and mem_ready_i=0.
//    When count reaches MEM_TIMEOUT: TRAP, cause 2; request dropped.
//    mem_ready_i in the same cycle as the limit: ready wins, no trap.
//  Condition check: ARM EQ..AL, 14 codes (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE) plus AL.
//  Counter width is $clog2(MEM_TIMEOUT+1). No combinational path from mem_ready_i to mem_req_o.
//  Minimum latencies (zero-wait memory):
//    failed condition: 2 cycles
//    B/BL: 3 cycles
//    DP: 4 cycles
//    STR: 4 cycles
//    LDR: 5 cycles
// STRUCTURE
//  Package ctrl_v2_pkg:
//    state encodings FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//    cls codes, pc_s/rd_s/w_rdata_s codes, trap cause codes, cond code constants
//  Sub-module cond_check: combinational (cond[3:0], nzcv[3:0]) -> pass. Instantiated once.
//  Main module: state register, timeout counter, trap_cause register, output decode.
// TESTING
//  1. Reset/zero-wait: release rst, cls=DP_WB, cond=AL, ready=1 always
//     -> FETCH,DECODE,EXEC,WB,FETCH repeating; write_reg_o in WB; state_o sequence 0,1,2,4,0.
//  2. Condition fail: cond=EQ(0000), nzcv=4'b0000
//     -> DECODE returns to FETCH; no LC_o/write_reg_o. With nzcv=4'b0100 the instruction executes.
//  3. Wait states: LDR, mem_ready_i low 3 cycles in MEM
//     -> mem_req_o high 4 cycles, mem_write_o=0, then WB with w_rdata_s_o=1, write_reg_o=1.
//  4. Timeout: MEM_TIMEOUT=4, ready never asserted in FETCH
//     -> TRAP after 4 waits; trap_o pulse, cause 2, pc_s_o=2, then FETCH.
//     Ready on the 4th cycle -> no trap.
//  5. Undefined/BL:
//     cls=UND -> TRAP cause 1.
//     cls=BL -> EXEC asserts write_pc_o, pc_s_o=1, write_reg_o, rd_s_o=1, w_rdata_s_o=2.
//  6. Async reset mid-MEM STR: drop rst between clock edges -> mem_req_o=0 immediately; restart at FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm_v2_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encodings, decoded instruction
// classes, datapath mux select codes, trap cause codes and ARM condition-code constants.
package mc_ctrl_fsm_v2_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  // Instruction classes supplied by the decoder on cls_i.
  localparam logic [2:0] ClsDpWb   = 3'd0;
  localparam logic [2:0] ClsDpNoWb = 3'd1;
  localparam logic [2:0] ClsLdr    = 3'd2;
  localparam logic [2:0] ClsStr    = 3'd3;
  localparam logic [2:0] ClsB      = 3'd4;
  localparam logic [2:0] ClsBl     = 3'd5;
  localparam logic [2:0] ClsUnd    = 3'd6;

  // PC source select.
  localparam logic [1:0] PcSPlus4  = 2'd0;
  localparam logic [1:0] PcSBranch = 2'd1;
  localparam logic [1:0] PcSTrap   = 2'd2;

  // Register-file write address select.
  localparam logic [1:0] RdSRd = 2'd0;
  localparam logic [1:0] RdSLr = 2'd1;

  // Register-file write data select.
  localparam logic [1:0] WdSAlu = 2'd0;
  localparam logic [1:0] WdSMem = 2'd1;
  localparam logic [1:0] WdSPc  = 2'd2;

  // Trap causes.
  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseUnd     = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;

  // ARM condition field encodings.
  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'ha;
  localparam logic [3:0] CondLt = 4'hb;
  localparam logic [3:0] CondGt = 4'hc;
  localparam logic [3:0] CondLe = 4'hd;
  localparam logic [3:0] CondAl = 4'he;
  localparam logic [3:0] CondNv = 4'hf;

  function automatic logic is_dp(input logic [2:0] cls);
    return (cls == ClsDpWb) || (cls == ClsDpNoWb);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_v2_if.sv
// Memory request/ready handshake between the control FSM and the memory system.
//   mem_req   : request outstanding (held until ready or timeout)
//   mem_write : request is a store (meaningful only with mem_req)
//   mem_ready : memory completes the current request this cycle
// master = control FSM, slave = memory.
interface mc_ctrl_fsm_v2_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl_fsm_v2_cond_check.sv
// ARM condition-code evaluator (purely combinational).
//   cond_i  : instruction condition field [31:28]
//   nzcv_i  : current flags {N,Z,C,V}
//   pass_o  : 1 when the instruction should execute; NV (4'b1111) never passes
module mc_ctrl_fsm_v2_cond_check
  import mc_ctrl_fsm_v2_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq:  pass_o = z;
      CondNe:  pass_o = !z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = !c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = !n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = !v;
      CondHi:  pass_o = c && !z;
      CondLs:  pass_o = !c || z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = !z && (n == v);
      CondLe:  pass_o = z || (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm_v2.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/writeback, gates execution on the
// ARM condition field, handles variable-latency memory and traps on undefined instructions or
// memory timeout.
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   instr_i         : IR contents (cond [31:28], S bit [20])
//   cls_i, nzcv_i   : decoded instruction class, current flags
//   mem             : memory handshake (master side)
//   write_ir_o, write_pc_o, pc_s_o, write_reg_o, rd_s_o, w_rdata_s_o : datapath controls
//   LA_o, LB_o, LC_o, LF_o : operand / result / flag latch strobes
//   trap_o, trap_cause_o   : trap entry pulse and sticky cause
//   state_o         : current state for debug
module mc_ctrl_fsm_v2
  import mc_ctrl_fsm_v2_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          COND_EN     = 1'b1,
  parameter bit          TRAP_ON_NV  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr_i,
  input  logic [2:0]               cls_i,
  input  logic [3:0]               nzcv_i,
  mc_ctrl_fsm_v2_if.master         mem,
  output logic                     write_ir_o,
  output logic                     write_pc_o,
  output logic [1:0]               pc_s_o,
  output logic                     write_reg_o,
  output logic [1:0]               rd_s_o,
  output logic [1:0]               w_rdata_s_o,
  output logic                     LA_o,
  output logic                     LB_o,
  output logic                     LC_o,
  output logic                     LF_o,
  output logic                     trap_o,
  output logic [1:0]               trap_cause_o,
  output logic [2:0]               state_o
);

  localparam int unsigned CntW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // The last wait cycle before the limit; the trap is taken in that cycle if ready is low.
  localparam logic [CntW-1:0] CntLast = (MEM_TIMEOUT == 0) ? '0 : CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;

  logic cond_pass;
  logic is_und;
  logic trap_und;
  logic exec_ok;
  logic at_limit;
  logic mem_ready;
  logic unused_instr;

  assign unused_instr = ^{instr_i[27:21], instr_i[19:0]};
  assign mem_ready    = mem.mem_ready;

  mc_ctrl_fsm_v2_cond_check u_cond_check (
    .cond_i (instr_i[31:28]),
    .nzcv_i (nzcv_i),
    .pass_o (cond_pass)
  );

  // Code 7 is unallocated and treated as undefined as well.
  assign is_und   = (cls_i == ClsUnd) || (cls_i == 3'd7);
  assign trap_und = is_und || (TRAP_ON_NV && (instr_i[31:28] == CondNv));
  assign exec_ok  = !COND_EN || cond_pass;
  assign at_limit = (MEM_TIMEOUT != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state. The counter is zero unless we stay in a memory state waiting for ready,
  // so it is implicitly cleared on every entry to FETCH/MEM.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cause_d = cause_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (at_limit) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        if (trap_und) begin
          state_d = StTrap;
          cause_d = CauseUnd;
        end else if (!exec_ok) begin
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_dp(cls_i)) begin
          state_d = StWb;
        end else if ((cls_i == ClsLdr) || (cls_i == ClsStr)) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (cls_i == ClsStr) ? StFetch : StWb;
        end else if (at_limit) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output decode. Everything is qualified by rst so a mid-operation reset drops the
  // request and all strobes immediately, not just at the next edge.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    write_ir_o    = 1'b0;
    write_pc_o    = 1'b0;
    pc_s_o        = PcSPlus4;
    write_reg_o   = 1'b0;
    rd_s_o        = RdSRd;
    w_rdata_s_o   = WdSAlu;
    LA_o          = 1'b0;
    LB_o          = 1'b0;
    LC_o          = 1'b0;
    LF_o          = 1'b0;
    trap_o        = 1'b0;
    if (rst) begin
      unique case (state_q)
        StFetch: begin
          mem.mem_req = 1'b1;
          write_ir_o  = mem_ready;
          write_pc_o  = mem_ready;
        end
        StDecode: begin
          LA_o = 1'b1;
          LB_o = 1'b1;
        end
        StExec: begin
          LC_o = 1'b1;
          LF_o = is_dp(cls_i) && instr_i[20];
          if ((cls_i == ClsB) || (cls_i == ClsBl)) begin
            write_pc_o = 1'b1;
            pc_s_o     = PcSBranch;
          end
          if (cls_i == ClsBl) begin
            write_reg_o = 1'b1;
            rd_s_o      = RdSLr;
            w_rdata_s_o = WdSPc;
          end
        end
        StMem: begin
          mem.mem_req   = 1'b1;
          mem.mem_write = (cls_i == ClsStr);
        end
        StWb: begin
          write_reg_o = (cls_i != ClsDpNoWb);
          w_rdata_s_o = (cls_i == ClsLdr) ? WdSMem : WdSAlu;
        end
        StTrap: begin
          write_pc_o = 1'b1;
          pc_s_o     = PcSTrap;
          trap_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// Self-checking bench: each instruction is expanded by a behavioural model into the expected
// per-cycle state/output sequence, which is then driven and compared cycle by cycle.
module tb_mc_ctrl_fsm_v2;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       write_ir;
    logic       write_pc;
    logic [1:0] pc_s;
    logic       write_reg;
    logic [1:0] rd_s;
    logic [1:0] w_rdata_s;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
    outs_t      o;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  cls = '0;
  logic [3:0]  nzcv = '0;
  logic        write_ir, write_pc, write_reg, la, lb, lc, lf, trap;
  logic [1:0]  pc_s, rd_s, w_rdata_s, trap_cause;
  logic [2:0]  state_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  logic [1:0] cur_cause = 2'd0;
  cyc_t exp_q[$];

  mc_ctrl_fsm_v2_if mif ();

  always #5 clk = ~clk;

  mc_ctrl_fsm_v2 #(
    .MEM_TIMEOUT (TO),
    .COND_EN     (1'b1),
    .TRAP_ON_NV  (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr),
    .cls_i        (cls),
    .nzcv_i       (nzcv),
    .mem          (mif.master),
    .write_ir_o   (write_ir),
    .write_pc_o   (write_pc),
    .pc_s_o       (pc_s),
    .write_reg_o  (write_reg),
    .rd_s_o       (rd_s),
    .w_rdata_s_o  (w_rdata_s),
    .LA_o         (la),
    .LB_o         (lb),
    .LC_o         (lc),
    .LF_o         (lf),
    .trap_o       (trap),
    .trap_cause_o (trap_cause),
    .state_o      (state_o)
  );

  // ---------------- reference model ----------------
  // ARM conditions come in complementary pairs: cond[3:1] picks the predicate, cond[0] inverts.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hf) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic outs_t blank();
    outs_t o;
    o = '0;
    o.cause = cur_cause;
    return o;
  endfunction

  function automatic void add(input logic [2:0] st, input logic rdy, input outs_t o);
    cyc_t e;
    e.st = st; e.rdy = rdy; e.o = o;
    exp_q.push_back(e);
  endfunction

  // Expected cycles of one memory transfer; returns 1 when it times out.
  function automatic bit mem_phase(input logic [2:0] st, input logic wr, input int waits);
    outs_t o;
    o = blank();
    o.mem_req = 1'b1;
    o.mem_write = wr;
    if (waits >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) add(st, 1'b0, o);
      return 1'b1;
    end
    for (int i = 0; i < waits; i++) add(st, 1'b0, o);
    if (st == 3'd0) begin
      o.write_ir = 1'b1;
      o.write_pc = 1'b1;
    end
    add(st, 1'b1, o);
    return 1'b0;
  endfunction

  function automatic void trap_cycle(input logic [1:0] c);
    outs_t o;
    cur_cause = c;
    o = blank();
    o.write_pc = 1'b1;
    o.pc_s = 2'd2;
    o.trap = 1'b1;
    add(3'd5, 1'($urandom_range(0, 1)), o);
  endfunction

  function automatic void wb_cycle(input logic [2:0] c);
    outs_t o;
    o = blank();
    o.write_reg = (c != 3'd1);
    o.w_rdata_s = (c == 3'd2) ? 2'd1 : 2'd0;
    add(3'd4, 1'($urandom_range(0, 1)), o);
  endfunction

  // Build the expected trace for one instruction, then drive and compare it.
  task automatic drive_instr(input logic [2:0] c, input logic [3:0] cond, input logic [3:0] f,
                             input logic s, input int wf, input int wm);
    outs_t o;
    outs_t act;
    exp_q.delete();
    instr = {cond, 7'($urandom), s, 20'($urandom)};
    cls = c;
    nzcv = f;
    if (mem_phase(3'd0, 1'b0, wf)) begin
      trap_cycle(2'd2);
    end else begin
      o = blank(); o.la = 1'b1; o.lb = 1'b1;
      add(3'd1, 1'($urandom_range(0, 1)), o);
      if (c == 3'd6 || cond == 4'hf) begin
        trap_cycle(2'd1);
      end else if (cond_ok(cond, f)) begin
        o = blank();
        o.lc = 1'b1;
        o.lf = s && (c <= 3'd1);
        if (c == 3'd4 || c == 3'd5) begin
          o.write_pc = 1'b1;
          o.pc_s = 2'd1;
        end
        if (c == 3'd5) begin
          o.write_reg = 1'b1;
          o.rd_s = 2'd1;
          o.w_rdata_s = 2'd2;
        end
        add(3'd2, 1'($urandom_range(0, 1)), o);
        if (c <= 3'd1) begin
          wb_cycle(c);
        end else if (c == 3'd2 || c == 3'd3) begin
          if (mem_phase(3'd3, c == 3'd3, wm)) trap_cycle(2'd2);
          else if (c == 3'd2) wb_cycle(c);
        end
      end
    end
    foreach (exp_q[i]) begin
      mif.mem_ready = exp_q[i].rdy;
      @(negedge clk);
      cyc_no++;
      act = {mif.mem_req, mif.mem_write, write_ir, write_pc, pc_s, write_reg, rd_s, w_rdata_s,
             la, lb, lc, lf, trap, trap_cause};
      checks++;
      if (state_o !== exp_q[i].st) begin
        errors++;
        $display("FAIL state cyc %0d cls %0d cond %h: got %0d want %0d", cyc_no, c, cond,
                 state_o, exp_q[i].st);
      end
      checks++;
      if (act !== exp_q[i].o) begin
        errors++;
        $display("FAIL outputs cyc %0d cls %0d cond %h st %0d: got %h want %h", cyc_no, c, cond,
                 exp_q[i].st, act, exp_q[i].o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    mif.mem_ready = 1'b1;
    cur_cause = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_o);
    end
    checks++;
    if ({mif.mem_req, mif.mem_write, write_ir, write_pc, pc_s, write_reg, rd_s, w_rdata_s,
         la, lb, lc, lf, trap, trap_cause} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_zero_wait_dp();
    for (int i = 0; i < 3; i++) drive_instr(3'd0, 4'he, 4'($urandom), 1'(i), 0, 0);
    drive_instr(3'd1, 4'he, 4'h0, 1'b1, 0, 0);
  endtask

  task automatic test_cond_fail();
    drive_instr(3'd0, 4'h0, 4'b0000, 1'b0, 0, 0);
    drive_instr(3'd0, 4'h0, 4'b0100, 1'b1, 0, 0);
    for (int cc = 0; cc < 15; cc++) drive_instr(3'd0, 4'(cc), 4'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_wait_states();
    drive_instr(3'd2, 4'he, 4'h0, 1'b0, 0, 3);
    drive_instr(3'd3, 4'he, 4'h0, 1'b0, 2, 1);
  endtask

  task automatic test_timeout();
    drive_instr(3'd0, 4'he, 4'h0, 1'b0, 4, 0);
    drive_instr(3'd0, 4'he, 4'h0, 1'b0, 3, 0);
    drive_instr(3'd2, 4'he, 4'h0, 1'b0, 0, 4);
    drive_instr(3'd3, 4'he, 4'h0, 1'b0, 0, 3);
  endtask

  task automatic test_undef_bl();
    drive_instr(3'd6, 4'he, 4'h0, 1'b0, 0, 0);
    drive_instr(3'd5, 4'he, 4'h0, 1'b0, 0, 0);
    drive_instr(3'd4, 4'he, 4'h0, 1'b0, 1, 0);
    drive_instr(3'd0, 4'hf, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive_instr(3'd6, 4'he, 4'h0, 1'b0, 0, 0);
    instr = {4'he, 28'h0};
    cls = 3'd3;
    mif.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mif.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({state_o, mif.mem_req, mif.mem_write} !== {3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_mem: got %b want %b", {state_o, mif.mem_req, mif.mem_write},
               {3'd3, 1'b1, 1'b1});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state_o, mif.mem_req, mif.mem_write, trap_cause} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0", {state_o, mif.mem_req, mif.mem_write,
                                                   trap_cause});
    end
    cur_cause = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_instr(3'd3, 4'he, 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic [3:0] cond;
    int wf, wm;
    for (int i = 0; i < 200; i++) begin
      c = 3'($urandom_range(0, 6));
      cond = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom);
      wf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
      wm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : 0;
      drive_instr(c, cond, 4'($urandom), 1'($urandom), wf, wm);
    end
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_zero_wait_dp();
    test_cond_fail();
    test_wait_states();
    test_timeout();
    test_undef_bl();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
